cond_logic_unit: RTL
====================

COND_LOGIC_UNIT -- requirements
Module: cond_logic_unit

Interface
REQ-001 Parameter: FLAGS_RESET, 4'b0000, reset value of the NZCV flag register.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 valid_in  in  1  decoded instruction present this cycle.
REQ-005 cond  in  4  instruction condition field, bits [31:28].
REQ-006 alu_flags  in  4  ALU result flags {N,Z,C,V}, bit 3 = N.
REQ-007 flag_w  in  2  flag-write request from the decoder; [1] updates N,Z and [0] updates C,V.
REQ-008 pcs  in  1  decoder PC-write request (branch or write to R15).
REQ-009 reg_w  in  1  decoder register-write request.
REQ-010 mem_w  in  1  decoder memory-write request.
REQ-011 stall  in  1  hold all state; no update this edge.
REQ-012 flush  in  1  discard the current instruction.
REQ-013 pc_src  out  1  registered, gated PC-write.
REQ-014 reg_write  out  1  registered, gated register-write.
REQ-015 mem_write  out  1  registered, gated memory-write.
REQ-016 valid_out  out  1  registered; outputs describe an instruction.
REQ-017 cond_ex  out  1  combinational condition result for the current inputs.
REQ-018 flags  out  4  current {N,Z,C,V} register.
REQ-019 undef  out  1  registered; asserted for one instruction when cond = 4'b1111 with valid_in.

Function
REQ-020 cond_ex SHALL be evaluated combinationally against the flag register (pre-update): 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 0110 V; 0111 !V; 1000 C&!Z; 1001 !C|Z; 1010 N==V; 1011 N!=V; 1100 !Z&(N==V); 1101 Z|(N!=V); 1110 1; 1111 0.
REQ-021 "Take" SHALL be defined as valid_in & cond_ex & !flush.
REQ-022 On an edge with !stall, flags[3:2] SHALL load alu_flags[3:2] iff take & flag_w[1], and flags[1:0] SHALL load alu_flags[1:0] iff take & flag_w[0]; otherwise the flags hold.
REQ-023 On an edge with !stall, pc_src/reg_write/mem_write SHALL load pcs/reg_w/mem_w ANDed with take, which gives a latency of 1 cycle.
REQ-024 On an edge with !stall, valid_out SHALL load valid_in & !flush; undef SHALL load valid_in & !flush & (cond==4'b1111).
REQ-025 A valid, non-executed instruction SHALL produce valid_out=1 with all three write outputs 0.
REQ-026 On an edge with stall=1 and flush=0, every register SHALL hold its value.
REQ-027 flush SHALL take priority over stall: with flush=1 the output registers SHALL clear to 0 and the flags SHALL hold, regardless of stall.
REQ-028 Back-to-back instructions SHALL see the flags written by the preceding taken instruction; there is no same-cycle bypass of alu_flags into cond_ex.
REQ-029 The condition decode SHALL be a single explicit 16-entry case with no latches.

Reset
REQ-030 While rst_n=0, flags SHALL be FLAGS_RESET and pc_src, reg_write, mem_write, valid_out and undef SHALL be 0, asynchronously.
REQ-031 An instruction presented during or at reset deassertion SHALL NOT update state until the first rising edge with rst_n=1.
REQ-032 Asserting reset mid-stall SHALL clear state immediately; the stall is not retained.

Verification
REQ-033 Reset, then cond=1110, flag_w=11, alu_flags=0100, reg_w=1 -> after 1 edge: flags=0100, reg_write=1, valid_out=1.
REQ-034 flags=0100, cond=0000 (EQ), pcs=1 -> pc_src=1; repeat with cond=0001 (NE) -> pc_src=0, valid_out=1.
REQ-035 flags=1000 (N=1,V=0), cond=1011 (LT), flag_w=10, alu_flags=0000 -> flags=0000 after the edge; next cond=1011 -> cond_ex=0.
REQ-036 Stall for 3 cycles while the inputs change -> outputs and flags constant; stall=1 with flush=1 -> valid_out=0 and flags unchanged.
REQ-037 cond=1111, valid_in=1, mem_w=1 -> undef=1, mem_write=0, flags unchanged.
REQ-038 rst_n pulsed low between edges while reg_write=1 -> reg_write=0 and flags=FLAGS_RESET before the next edge.

Source files
------------

// File: rtl/cond_logic_unit.sv
// Condition-evaluation and flag-register stage: decides whether the decoded
// instruction executes, gates its write requests and maintains the NZCV flags.
module cond_logic_unit #(
  parameter logic [3:0] FLAGS_RESET = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_in,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic [1:0] flag_w,
  input  logic       pcs,
  input  logic       reg_w,
  input  logic       mem_w,
  input  logic       stall,
  input  logic       flush,
  output logic       pc_src,
  output logic       reg_write,
  output logic       mem_write,
  output logic       valid_out,
  output logic       cond_ex,
  output logic [3:0] flags,
  output logic       undef
);

  localparam logic [3:0] COND_NV = 4'b1111;

  logic [3:0] flags_q, flags_d;
  logic       pc_src_q, pc_src_d;
  logic       reg_write_q, reg_write_d;
  logic       mem_write_q, mem_write_d;
  logic       valid_out_q, valid_out_d;
  logic       undef_q, undef_d;
  logic       cond_ex_s;
  logic       take_s;

  // Evaluates a condition code against {N,Z,C,V}; 1111 never executes.
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v, r;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'b0000: r = z;
      4'b0001: r = ~z;
      4'b0010: r = cy;
      4'b0011: r = ~cy;
      4'b0100: r = n;
      4'b0101: r = ~n;
      4'b0110: r = v;
      4'b0111: r = ~v;
      4'b1000: r = cy & ~z;
      4'b1001: r = ~cy | z;
      4'b1010: r = (n == v);
      4'b1011: r = (n != v);
      4'b1100: r = ~z & (n == v);
      4'b1101: r = z | (n != v);
      4'b1110: r = 1'b1;
      4'b1111: r = 1'b0;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Condition result uses the registered flags only; no alu_flags bypass.
  always_comb begin
    cond_ex_s = cond_eval(cond, flags_q);
    take_s    = valid_in & cond_ex_s & ~flush;
  end

  // Next-state: flush clears the outputs (flags hold) and outranks stall.
  always_comb begin
    flags_d     = flags_q;
    pc_src_d    = pc_src_q;
    reg_write_d = reg_write_q;
    mem_write_d = mem_write_q;
    valid_out_d = valid_out_q;
    undef_d     = undef_q;
    if (flush) begin
      pc_src_d    = 1'b0;
      reg_write_d = 1'b0;
      mem_write_d = 1'b0;
      valid_out_d = 1'b0;
      undef_d     = 1'b0;
    end else if (!stall) begin
      if (take_s & flag_w[1]) begin
        flags_d[3:2] = alu_flags[3:2];
      end else begin
        flags_d[3:2] = flags_q[3:2];
      end
      if (take_s & flag_w[0]) begin
        flags_d[1:0] = alu_flags[1:0];
      end else begin
        flags_d[1:0] = flags_q[1:0];
      end
      pc_src_d    = pcs & take_s;
      reg_write_d = reg_w & take_s;
      mem_write_d = mem_w & take_s;
      valid_out_d = valid_in;
      undef_d     = valid_in & (cond == COND_NV);
    end else begin
      flags_d     = flags_q;
      pc_src_d    = pc_src_q;
      reg_write_d = reg_write_q;
      mem_write_d = mem_write_q;
      valid_out_d = valid_out_q;
      undef_d     = undef_q;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q     <= FLAGS_RESET;
      pc_src_q    <= 1'b0;
      reg_write_q <= 1'b0;
      mem_write_q <= 1'b0;
      valid_out_q <= 1'b0;
      undef_q     <= 1'b0;
    end else begin
      flags_q     <= flags_d;
      pc_src_q    <= pc_src_d;
      reg_write_q <= reg_write_d;
      mem_write_q <= mem_write_d;
      valid_out_q <= valid_out_d;
      undef_q     <= undef_d;
    end
  end

  assign cond_ex   = cond_ex_s;
  assign flags     = flags_q;
  assign pc_src    = pc_src_q;
  assign reg_write = reg_write_q;
  assign mem_write = mem_write_q;
  assign valid_out = valid_out_q;
  assign undef     = undef_q;

endmodule
